pe_bus_arb: RTL and testbench

- Parametrised multi-channel bus front end that lets NUM_CH requesters (fetch units, future load/store units) share one processing-element bus port.
- Arbitrates round-robin and issues one read at a time.
- Returns the read data to the winning channel, or an error if the bus times out.
- Sits between the per-PE requesters and the external address/data bus; replaces the direct fetch-to-bus wiring.

---
 rtl/pe_bus_arb_pkg.sv | 5 +
 rtl/pe_bus_arb_if.sv | 25 ++
 rtl/pe_bus_arb_rr_pick.sv | 25 ++
 rtl/pe_bus_arb.sv | 93 +++++++++
 tb/tb_pe_bus_arb.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pe_bus_arb_pkg.sv
// bus_pkg: shared state type and constants for the PE bus arbiter slice
package bus_pkg;
    typedef enum logic {ARB_IDLE, ARB_ISSUE} arb_state_t;
    localparam logic ERR_DATA = 1'b1;
endpackage

// File: rtl/pe_bus_arb_if.sv
// pe_bus_arb_if: requester-side and external-bus signals of the PE bus arbiter
interface pe_bus_arb_if #(
    parameter int NUM_CH = 4,
    parameter int AD_LEN = 32,
    parameter int BUS_WIDTH = 32
);
    logic [NUM_CH-1:0] ch_req_i;
    logic [NUM_CH*AD_LEN-1:0] ch_ad_i;
    logic [NUM_CH-1:0] ch_gnt_o;
    logic [NUM_CH-1:0] ch_valid_o;
    logic [NUM_CH-1:0] ch_err_o;
    logic [BUS_WIDTH-1:0] ch_data_o;
    logic bus_req_o;
    logic [AD_LEN-1:0] bus_ad_o;
    logic [BUS_WIDTH-1:0] bus_data_i;
    logic bus_ack_i;
    modport slave (
        input ch_req_i, ch_ad_i, bus_data_i, bus_ack_i,
        output ch_gnt_o, ch_valid_o, ch_err_o, ch_data_o, bus_req_o, bus_ad_o
    );
    modport master (
        output ch_req_i, ch_ad_i, bus_data_i, bus_ack_i,
        input ch_gnt_o, ch_valid_o, ch_err_o, ch_data_o, bus_req_o, bus_ad_o
    );
endinterface

// File: rtl/pe_bus_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request after last, wrapping
module rr_pick #(
    parameter int NUM_CH = 4,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic found,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] c;
    // Scan farthest-to-nearest so the nearest candidate after last overwrites the rest
    always_comb begin
        found = 1'b0;
        idx = '0;
        c = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            c = IDX_W'((int'(last) + i) % NUM_CH);
            if (req[c]) begin
                found = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/pe_bus_arb.sv
// pe_bus_arb: round-robin front end sharing one read bus port among NUM_CH requesters
module pe_bus_arb
    import bus_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int AD_LEN = 32,
    parameter int BUS_WIDTH = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input logic clk_i,
    input logic reset_i,
    pe_bus_arb_if.slave bus
);
    localparam int CH_IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;

    arb_state_t state, state_d;
    logic [CH_IDX_W-1:0] own_q, own_d, rr_last, rr_d, win;
    logic found, timed_out;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [AD_LEN-1:0] ad_q, ad_d;
    logic [NUM_CH-1:0] gnt_d, valid_d, err_d;
    logic [BUS_WIDTH-1:0] data_d;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req(bus.ch_req_i),
        .last(rr_last),
        .found(found),
        .idx(win)
    );

    assign bus.bus_req_o = state == ARB_ISSUE;
    assign bus.bus_ad_o = ad_q;
    // cnt counts completed ISSUE cycles, so the edge ending the last allowed cycle sees TIMEOUT_CYC-1
    assign timed_out = TIMEOUT_CYC != 0 && cnt == CNT_W'(TIMEOUT_CYC - 1);

    always_comb begin
        state_d = state;
        own_d = own_q;
        rr_d = rr_last;
        cnt_d = cnt;
        ad_d = ad_q;
        gnt_d = '0;
        valid_d = '0;
        err_d = '0;
        data_d = bus.ch_data_o;
        if (state == ARB_IDLE) begin
            if (found) begin
                state_d = ARB_ISSUE;
                own_d = win;
                rr_d = win;
                cnt_d = '0;
                ad_d = bus.ch_ad_i[int'(win)*AD_LEN +: AD_LEN];
                gnt_d = NUM_CH'(1) << win;
            end
        end else if (bus.bus_ack_i) begin
            state_d = ARB_IDLE;
            valid_d = NUM_CH'(1) << own_q;
            data_d = bus.bus_data_i;
        end else if (timed_out) begin
            state_d = ARB_IDLE;
            valid_d = NUM_CH'(1) << own_q;
            err_d = NUM_CH'(1) << own_q;
            data_d = {BUS_WIDTH{ERR_DATA}};
        end else begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= ARB_IDLE;
            own_q <= '0;
            rr_last <= CH_IDX_W'(NUM_CH - 1);
            cnt <= '0;
            ad_q <= '0;
            bus.ch_gnt_o <= '0;
            bus.ch_valid_o <= '0;
            bus.ch_err_o <= '0;
            bus.ch_data_o <= '0;
        end else begin
            state <= state_d;
            own_q <= own_d;
            rr_last <= rr_d;
            cnt <= cnt_d;
            ad_q <= ad_d;
            bus.ch_gnt_o <= gnt_d;
            bus.ch_valid_o <= valid_d;
            bus.ch_err_o <= err_d;
            bus.ch_data_o <= data_d;
        end
    end
endmodule

// File: tb/tb_pe_bus_arb.sv
// tb_pe_bus_arb: directed vectors for pe_bus_arb with hand-computed expectations
module tb_pe_bus_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [3:0] g;
    int t_last;
    int n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_bus_arb_if #(.NUM_CH(4), .AD_LEN(32), .BUS_WIDTH(32)) bif ();
    pe_bus_arb #(.NUM_CH(4), .AD_LEN(32), .BUS_WIDTH(32), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk),
        .reset_i(rst),
        .bus(bif)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bif.ch_req_i = '0;
        bif.bus_ack_i = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output logic [3:0] gv);
        int k = 0;
        do begin
            step;
            k++;
        end while (bif.ch_gnt_o == 4'b0 && k < 8);
        gv = bif.ch_gnt_o;
    endtask

    // Bus answers one cycle after it sees bus_req; returns at the cycle showing ch_valid_o
    task automatic bus_ack(input logic [31:0] d);
        step;
        bif.bus_data_i = d;
        bif.bus_ack_i = 1'b1;
        step;
        bif.bus_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif.ch_req_i = '0;
        bif.ch_ad_i = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
        bif.bus_data_i = '0;
        bif.bus_ack_i = 1'b0;
        step;
        step;
        chk("rst_gnt", 32'(bif.ch_gnt_o), 32'h0);
        chk("rst_valid", 32'(bif.ch_valid_o), 32'h0);
        chk("rst_err", 32'(bif.ch_err_o), 32'h0);
        chk("rst_data", bif.ch_data_o, 32'h0);
        chk("rst_req", 32'(bif.bus_req_o), 32'h0);
        chk("rst_ad", bif.bus_ad_o, 32'h0);

        // single read on channel 0
        rst = 1'b0;
        bif.ch_req_i = 4'b0001;
        wait_gnt(g);
        chk("t1_gnt", 32'(g), 32'h1);
        chk("t1_busreq", 32'(bif.bus_req_o), 32'h1);
        chk("t1_ad", bif.bus_ad_o, 32'h1000);
        bif.ch_req_i = '0;
        step;
        chk("t1_gnt_pulse", 32'(bif.ch_gnt_o), 32'h0);
        chk("t1_busreq2", 32'(bif.bus_req_o), 32'h1);
        bif.bus_data_i = 32'hDEADBEEF;
        bif.bus_ack_i = 1'b1;
        step;
        bif.bus_ack_i = 1'b0;
        chk("t1_valid", 32'(bif.ch_valid_o), 32'h1);
        chk("t1_err", 32'(bif.ch_err_o), 32'h0);
        chk("t1_data", bif.ch_data_o, 32'hDEADBEEF);
        chk("t1_busreq_off", 32'(bif.bus_req_o), 32'h0);
        step;
        chk("t1_valid_pulse", 32'(bif.ch_valid_o), 32'h0);
        chk("t1_ad_hold", bif.bus_ad_o, 32'h1000);
        chk("t1_data_hold", bif.ch_data_o, 32'hDEADBEEF);

        // round robin with all channels requesting
        do_reset;
        bif.ch_req_i = 4'b1111;
        t_last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g);
            chk("rr_gnt", 32'(g), 32'(1) << (k % 4));
            chk("rr_ad", bif.bus_ad_o, 32'h1000 * (k % 4 + 1));
            if (k > 0) chk("rr_gap", 32'(cyc - t_last), 32'd3);
            t_last = cyc;
            bus_ack(32'hA0 + k);
            chk("rr_valid", 32'(bif.ch_valid_o), 32'(1) << (k % 4));
            chk("rr_data", bif.ch_data_o, 32'hA0 + k);
        end
        bif.ch_req_i = '0;

        // timeout on channel 2
        do_reset;
        bif.ch_req_i = 4'b0100;
        wait_gnt(g);
        chk("to_gnt", 32'(g), 32'h4);
        bif.ch_req_i = '0;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            step;
            if (!bif.bus_req_o) break;
            n++;
        end
        chk("to_len", 32'(n), 32'd16);
        chk("to_valid", 32'(bif.ch_valid_o), 32'h4);
        chk("to_err", 32'(bif.ch_err_o), 32'h4);
        chk("to_data", bif.ch_data_o, 32'hFFFFFFFF);
        step;
        chk("to_err_pulse", 32'(bif.ch_err_o), 32'h0);
        chk("to_idle", 32'(bif.bus_req_o), 32'h0);

        // ack on the 16th ISSUE cycle beats the timeout
        bif.ch_req_i = 4'b0010;
        wait_gnt(g);
        chk("bd_gnt", 32'(g), 32'h2);
        bif.ch_req_i = '0;
        repeat (15) step;
        chk("bd_busreq", 32'(bif.bus_req_o), 32'h1);
        bif.bus_data_i = 32'hCAFEF00D;
        bif.bus_ack_i = 1'b1;
        step;
        bif.bus_ack_i = 1'b0;
        chk("bd_valid", 32'(bif.ch_valid_o), 32'h2);
        chk("bd_err", 32'(bif.ch_err_o), 32'h0);
        chk("bd_data", bif.ch_data_o, 32'hCAFEF00D);

        // reset mid-transaction abandons it and restores channel 0 priority
        bif.ch_req_i = 4'b0010;
        wait_gnt(g);
        chk("rs_gnt1", 32'(g), 32'h2);
        bif.ch_req_i = '0;
        step;
        rst = 1'b1;
        step;
        chk("rs_busreq", 32'(bif.bus_req_o), 32'h0);
        chk("rs_valid", 32'(bif.ch_valid_o), 32'h0);
        chk("rs_err", 32'(bif.ch_err_o), 32'h0);
        rst = 1'b0;
        bif.ch_req_i = 4'b0011;
        wait_gnt(g);
        chk("rs_gnt0", 32'(g), 32'h1);
        bus_ack(32'h55);
        chk("rs_valid0", 32'(bif.ch_valid_o), 32'h1);
        wait_gnt(g);
        chk("rs_gnt_next", 32'(g), 32'h2);
        bif.ch_req_i = '0;
        bus_ack(32'h66);
        chk("rs_valid1", 32'(bif.ch_valid_o), 32'h2);
        chk("rs_data1", bif.ch_data_o, 32'h66);

        // stray ack while idle is ignored
        step;
        bif.bus_data_i = 32'h12345678;
        bif.bus_ack_i = 1'b1;
        step;
        bif.bus_ack_i = 1'b0;
        chk("id_valid", 32'(bif.ch_valid_o), 32'h0);
        chk("id_data", bif.ch_data_o, 32'h66);
        chk("id_busreq", 32'(bif.bus_req_o), 32'h0);
        step;
        chk("id_valid2", 32'(bif.ch_valid_o), 32'h0);
        chk("id_data2", bif.ch_data_o, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
